dmem_sram_responder: RTL and testbench
======================================

Name: dmem_sram_responder

Overview:
Responder end of the data-bus request handshake driven by the commit/exception stage. Commit drives req/wt/addr/wd/size/write_en and waits for addr_ok. This block accepts those requests into a small in-order queue and services them against on-chip synchronous byte-enable block RAM, with programmable wait states. Each completion is returned as a one-cycle data_ok pulse, carrying rdata for loads. It sits between the commit stage and the data RAM in FPGA/sim builds.

Parameters:
DEPTH, 2, request queue entries (power of two, ≥1)
LATENCY, 0, extra wait-state cycles inserted before each RAM access (0..15)
RAM_AW, 14, RAM word-address width; RAM holds 2^RAM_AW 32-bit words

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-low
req  input  1  request valid from commit stage
wt  input  1  1 = store, 0 = load
addr  input  32  byte address
wd  input  32  store data, already lane-aligned
size  input  2  0 = byte, 1 = half, 2 = word; informational/assertion only
write_en  input  4  byte strobes; may be nonzero on loads, so it must be gated by wt
addr_ok  output  1  request accepted this cycle
data_ok  output  1  one-cycle completion pulse
rdata  output  32  load data, valid only with data_ok on a load
ram_en  output  1  RAM access enable
ram_we  output  4  RAM byte write enables
ram_addr  output  RAM_AW  RAM word address
ram_wd  output  32  RAM write data
ram_rd  input  32  RAM read data, valid the cycle after ram_en

Behaviour:
- Reset (reset == 0 at a clk edge): queue emptied, state IDLE, wait counter 0.
  - While reset is low, addr_ok, data_ok, ram_en, ram_we and rdata are all forced to 0.
  - Reset mid-operation drops all queued and in-flight requests. No data_ok is issued for them.
- Accept rule: addr_ok = req & (count < DEPTH).
  - Deasserted when the queue is full, even if a pop happens in the same cycle.
  - No flush input exists: every accepted request always completes.
- Push on req & addr_ok: the entry stores {wt, addr, wd, size, strb = wt ? write_en : 4'b0}.
  - The entry is visible at the head one cycle later.
- Service FSM, states IDLE, WAIT, ACCESS, RESP:
  - IDLE: if the queue is non-empty, go to WAIT with counter = LATENCY-1 when LATENCY > 0, otherwise go to ACCESS.
  - WAIT: decrement the counter; go to ACCESS when the counter is 0.
  - ACCESS: ram_en = 1, ram_we = head.strb, ram_addr = head.addr[RAM_AW+1:2], ram_wd = head.wd. Next state is RESP.
  - RESP: data_ok = 1. rdata = ram_rd if head.wt == 0, else 0. Pop the head.
    - If count > 1 before the pop, go directly to WAIT/ACCESS following the IDLE rule.
    - Otherwise go to IDLE.
- Outside ACCESS: ram_en = 0 and ram_we = 0. Outside RESP: data_ok = 0 and rdata = 0.
- Latency with LATENCY = L: accept at cycle T → ACCESS at T+1+L → data_ok at T+2+L. Back-to-back throughput is one completion per 2+L cycles.
- Ordering: strictly in order. The data_ok count always equals the accepted count (modulo reset).
- Push and pop in the same cycle are legal: count is unchanged, head/tail pointers wrap modulo DEPTH.
- addr[31:RAM_AW+2] and addr[1:0] are ignored; address decode is upstream.
- Assertion (sim only): on an accepted store, write_en must match size and addr[1:0]. A byte store sets one strobe, a half-word store sets 2'b11 at [1:0] or [3:2], and a word store sets all four strobes.

Decomposition:
- Shared package: dbus_req_t struct {wt, addr, wd, size, strb}; responder state enum {IDLE, WAIT, ACCESS, RESP}; size encodings (SIZE_B/H/W).
- Sub-module dbus_req_fifo (DEPTH, dbus_req_t):
  - push/pop/full/empty/count, head output.
  - Synchronous active-low reset.
- The top level holds the FSM, wait counter and RAM drive.

Test Plan:
- LATENCY=0, RAM word 0x10 = 0xDEADBEEF; single load at addr 0x40 → addr_ok same cycle, ram_en at T+1 with ram_addr 0x10, data_ok at T+2 with rdata 0xDEADBEEF.
- Store byte: wt=1, addr 0x43, wd 0xAA000000, write_en 4'b1000; then load 0x40 → ram_we 4'b1000 once; load returns 0xAAADBEEF; store data_ok has rdata 0.
- Load issued with write_en 4'b1111 (commit mux artifact) → ram_we stays 0; RAM contents unchanged.
- DEPTH=2, req held high for 4 requests → addr_ok high for first 2, low while full, next accept in the cycle after the first RESP pop; four data_ok pulses in issue order.
- LATENCY=3 → data_ok exactly 5 cycles after accept; back-to-back completions spaced 5 cycles.
- Reset asserted low for one cycle while in WAIT with 2 queued → no data_ok afterward; addr_ok = req in the first cycle after reset release; ram_en stays 0 until a new request is accepted.

Source files
------------

// File: rtl/dmem_sram_responder_pkg.sv
// Shared types for the data-bus responder: queued request record, service
// FSM states and access-size encodings.
package dmem_sram_responder_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef struct packed {
        logic        wt;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [1:0]  size;
        logic [3:0]  strb;
    } dbus_req_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } resp_state_t;

    // True when a store's byte strobes agree with its size and low address bits.
    function automatic logic strb_legal(input logic [1:0] size, input logic [1:0] lo,
                                        input logic [3:0] strb);
        case (size)
            SIZE_B:  strb_legal = (strb == (4'b0001 << lo));
            SIZE_H:  strb_legal = (lo == 2'd0 && strb == 4'b0011) ||
                                  (lo == 2'd2 && strb == 4'b1100);
            SIZE_W:  strb_legal = (strb == 4'b1111);
            default: strb_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_sram_responder_fifo.sv
// In-order request queue for the responder; the head entry is readable
// combinationally the cycle after it was pushed.
module dbus_req_fifo
    import dmem_sram_responder_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  dbus_req_t     push_data,
    output dbus_req_t     head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    dbus_req_t     mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= bump(wr_ptr);
            if (pop)  rd_ptr <= bump(rd_ptr);
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // Storage is not reset; an entry is only ever read after it was written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/dmem_sram_responder.sv
// Data-bus responder: queues commit-stage requests and services them in order
// against synchronous byte-enable block RAM with optional wait states.
module dmem_sram_responder
    import dmem_sram_responder_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int LATENCY = 0,
    parameter int RAM_AW  = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              wt,
    input  logic [31:0]       addr,
    input  logic [31:0]       wd,
    input  logic [1:0]        size,
    input  logic [3:0]        write_en,
    output logic              addr_ok,
    output logic              data_ok,
    output logic [31:0]       rdata,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wd,
    input  logic [31:0]       ram_rd
);

    localparam int CW = $clog2(DEPTH + 1);

    resp_state_t   state, state_next;
    logic [3:0]    wait_cnt, wait_cnt_next;
    logic          start;
    logic          push, pop, full, empty;
    logic [CW-1:0] count;
    dbus_req_t     push_data, head;
    logic          unused_head_bits;

    // Loads may arrive with stray strobes from the commit mux, so they are dropped here.
    assign push_data = '{wt: wt, addr: addr, wd: wd, size: size,
                         strb: wt ? write_en : 4'b0000};
    assign addr_ok   = reset && req && !full;
    assign push      = addr_ok;
    assign pop       = reset && (state == RESP);

    dbus_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        start         = 1'b0;
        ram_en        = 1'b0;
        ram_we        = 4'b0000;
        data_ok       = 1'b0;
        rdata         = 32'h0;
        case (state)
            IDLE: start = !empty || push;
            WAIT: begin
                if (wait_cnt == 4'd0)
                    state_next = ACCESS;
                else
                    wait_cnt_next = wait_cnt - 4'd1;
            end
            ACCESS: begin
                ram_en     = 1'b1;
                ram_we     = head.strb;
                state_next = RESP;
            end
            RESP: begin
                data_ok = 1'b1;
                rdata   = head.wt ? 32'h0 : ram_rd;
                if (count > CW'(1))
                    start = 1'b1;
                else
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // A request entering service gets LATENCY wait cycles before its RAM access.
        if (start) begin
            if (LATENCY > 0) begin
                state_next    = WAIT;
                wait_cnt_next = 4'(LATENCY - 1);
            end else begin
                state_next = ACCESS;
            end
        end
        if (!reset) begin
            ram_en  = 1'b0;
            ram_we  = 4'b0000;
            data_ok = 1'b0;
            rdata   = 32'h0;
        end
    end

    assign ram_addr = head.addr[RAM_AW+1:2];
    assign ram_wd   = head.wd;

    assign unused_head_bits = ^{head.size, head.addr[31:RAM_AW+2], head.addr[1:0]};

    store_strb_legal: assert property (@(posedge clk) disable iff (!reset)
        (push && wt) |-> strb_legal(size, addr[1:0], write_en));

endmodule

// File: tb/tb_dmem_sram_responder.sv
// Bench for dmem_sram_responder: directed vector table, hand-written latency and
// reset sequences, and a randomized run against a completion-schedule model.
module tb_dmem_sram_responder;
    import dmem_sram_responder_pkg::*;

    typedef struct {
        logic        rst, req, wt;
        logic [31:0] addr, wd;
        logic [1:0]  size;
        logic [3:0]  we;
        logic        e_aok, e_dok;
        logic [31:0] e_rdata;
        logic        e_en;
        logic [3:0]  e_we;
        logic [7:0]  e_raddr;
    } vec_t;

    typedef struct {
        int          c;
        logic        wt;
        logic [7:0]  idx;
        logic [31:0] wd;
        logic [3:0]  strb;
    } pend_t;

    logic        clk = 1'b0;
    logic        rst_v [2], req_v [2], wt_v [2], aok_v [2], dok_v [2], en_v [2];
    logic [31:0] addr_v [2], wd_v [2], rdata_v [2], rwd_v [2], rrd_v [2];
    logic [1:0]  size_v [2];
    logic [3:0]  we_v [2], rwe_v [2];
    logic [7:0]  raddr_v [2];
    logic [31:0] mem [2][256];
    logic [31:0] shadow [2][256];

    pend_t pend [2][4];
    int    pc [2];
    int    last_c [2];
    int    tcyc = 0;
    bit    model_on = 1'b0;
    int    checks = 0;
    int    failures = 0;
    vec_t  vecs [$];

    always #5 clk = ~clk;

    dmem_sram_responder #(.DEPTH(2), .LATENCY(0), .RAM_AW(8)) u0 (
        .clk(clk), .reset(rst_v[0]), .req(req_v[0]), .wt(wt_v[0]), .addr(addr_v[0]),
        .wd(wd_v[0]), .size(size_v[0]), .write_en(we_v[0]), .addr_ok(aok_v[0]),
        .data_ok(dok_v[0]), .rdata(rdata_v[0]), .ram_en(en_v[0]), .ram_we(rwe_v[0]),
        .ram_addr(raddr_v[0]), .ram_wd(rwd_v[0]), .ram_rd(rrd_v[0]));

    dmem_sram_responder #(.DEPTH(2), .LATENCY(3), .RAM_AW(8)) u1 (
        .clk(clk), .reset(rst_v[1]), .req(req_v[1]), .wt(wt_v[1]), .addr(addr_v[1]),
        .wd(wd_v[1]), .size(size_v[1]), .write_en(we_v[1]), .addr_ok(aok_v[1]),
        .data_ok(dok_v[1]), .rdata(rdata_v[1]), .ram_en(en_v[1]), .ram_we(rwe_v[1]),
        .ram_addr(raddr_v[1]), .ram_wd(rwd_v[1]), .ram_rd(rrd_v[1]));

    // Synchronous byte-enable RAM: read data appears the cycle after ram_en.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (en_v[k]) begin
                rrd_v[k] <= mem[k][raddr_v[k]];
                for (int b = 0; b < 4; b++)
                    if (rwe_v[k][b]) mem[k][raddr_v[k]][8*b +: 8] <= rwd_v[k][8*b +: 8];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int k, input logic rst, input logic req, input logic wt,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [1:0] size, input logic [3:0] we);
        rst_v[k] = rst; req_v[k] = req; wt_v[k] = wt; addr_v[k] = addr;
        wd_v[k] = wd; size_v[k] = size; we_v[k] = we;
    endtask

    function automatic vec_t reqRow(logic wt, logic [31:0] addr, logic [31:0] wd, logic [1:0] size,
                                    logic [3:0] we, logic aok, logic dok, logic [31:0] rdata,
                                    logic en, logic [3:0] rwe, logic [7:0] raddr);
        return '{1'b1, 1'b1, wt, addr, wd, size, we, aok, dok, rdata, en, rwe, raddr};
    endfunction

    function automatic vec_t outRow(logic dok, logic [31:0] rdata, logic en, logic [3:0] rwe,
                                    logic [7:0] raddr);
        return '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, SIZE_W, 4'h0, 1'b0, dok, rdata, en, rwe, raddr};
    endfunction

    task automatic waitDataOk(input int k, input int limit, output int n);
        n = 0;
        while (n < limit) begin
            @(negedge clk);
            n++;
            if (dok_v[k]) return;
        end
        n = -1;
    endtask

    // Reference: completion cycle of each accepted request follows from the accept
    // cycle, the previous completion and the wait-state count; data from an in-order shadow RAM.
    task automatic modelStep(input int k);
        int          lat, c;
        logic [31:0] exp_rd;
        logic        exp_aok;
        lat = (k == 0) ? 0 : 3;
        if (!rst_v[k]) begin
            checkOutput($sformatf("u%0d.rst_aok", k), 32'(aok_v[k]), 0);
            checkOutput($sformatf("u%0d.rst_dok", k), 32'(dok_v[k]), 0);
            checkOutput($sformatf("u%0d.rst_en", k), 32'(en_v[k]), 0);
            checkOutput($sformatf("u%0d.rst_rdata", k), rdata_v[k], 0);
            pc[k] = 0;
            last_c[k] = -100;
            for (int i = 0; i < 256; i++) shadow[k][i] = mem[k][i];
            return;
        end
        exp_aok = req_v[k] && (pc[k] < 2);
        checkOutput($sformatf("u%0d.aok", k), 32'(aok_v[k]), 32'(exp_aok));
        if (pc[k] > 0 && pend[k][0].c == tcyc) begin
            if (pend[k][0].wt) begin
                exp_rd = 32'h0;
                for (int b = 0; b < 4; b++)
                    if (pend[k][0].strb[b])
                        shadow[k][pend[k][0].idx][8*b +: 8] = pend[k][0].wd[8*b +: 8];
            end else begin
                exp_rd = shadow[k][pend[k][0].idx];
            end
            checkOutput($sformatf("u%0d.dok", k), 32'(dok_v[k]), 1);
            checkOutput($sformatf("u%0d.rdata", k), rdata_v[k], exp_rd);
            for (int i = 0; i < 3; i++) pend[k][i] = pend[k][i+1];
            pc[k]--;
        end else begin
            checkOutput($sformatf("u%0d.idle_dok", k), 32'(dok_v[k]), 0);
            checkOutput($sformatf("u%0d.idle_rdata", k), rdata_v[k], 0);
        end
        checkOutput($sformatf("u%0d.ram_en", k), 32'(en_v[k]),
                    32'(pc[k] > 0 && pend[k][0].c == tcyc + 1));
        if (exp_aok) begin
            if (tcyc < last_c[k])       c = last_c[k] + 2 + lat;
            else if (tcyc == last_c[k]) c = tcyc + 3 + lat;
            else                        c = tcyc + 2 + lat;
            pend[k][pc[k]] = '{c, wt_v[k], addr_v[k][9:2], wd_v[k], wt_v[k] ? we_v[k] : 4'h0};
            pc[k]++;
            last_c[k] = c;
        end
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            tcyc++;
            for (int k = 0; k < 2; k++) modelStep(k);
        end
    end

    task automatic randomDrive(input int k);
        logic       w;
        logic [1:0] sz, lo;
        logic [3:0] st;
        w  = 1'($urandom_range(0, 1));
        sz = 2'($urandom_range(0, 2));
        if (w) begin
            case (sz)
                SIZE_B:  begin lo = 2'($urandom_range(0, 3)); st = 4'b0001 << lo; end
                SIZE_H:  begin lo = $urandom_range(0, 1) ? 2'd2 : 2'd0; st = lo[1] ? 4'b1100 : 4'b0011; end
                default: begin lo = 2'd0; st = 4'hF; end
            endcase
        end else begin
            lo = 2'($urandom_range(0, 3));
            st = 4'($urandom_range(0, 15));
        end
        applyStimulus(k, $urandom_range(0, 99) >= 2, $urandom_range(0, 99) < 65, w,
                      {22'($urandom), 3'b000, 5'($urandom_range(0, 31)), lo}, $urandom, sz, st);
    endtask

    initial begin
        int n, nd, ne, first;
        logic [31:0] rd;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 256; i++) mem[k][i] = 32'h1000_0000 + 32'(i) + (32'(k) << 16);
            applyStimulus(k, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, SIZE_W, 4'h0);
        end
        mem[0][16] = 32'hDEADBEEF;
        mem[0][17] = 32'h12345678;
        for (int i = 0; i < 4; i++) mem[0][32+i] = 32'hA0A0_0000 + 32'(i);
        mem[1][64] = 32'h5555_0001;
        mem[1][65] = 32'h5555_0002;
        mem[1][66] = 32'h5555_0003;
        mem[1][69] = 32'h6969_0069;
        repeat (2) @(posedge clk);

        // Directed table on the zero-wait-state instance.
        vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h40, 32'hFFFF_FFFF, SIZE_W, 4'hF,
                         1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 8'h0});
        vecs.push_back(outRow(0, 0, 0, 0, 0));
        vecs.push_back(reqRow(0, 32'h40, 0, SIZE_W, 4'h0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(outRow(0, 0, 1, 4'h0, 8'h10));
        vecs.push_back(outRow(1, 32'hDEADBEEF, 0, 0, 0));
        vecs.push_back(reqRow(1, 32'h43, 32'hAA00_0000, SIZE_B, 4'b1000, 1, 0, 0, 0, 0, 0));
        vecs.push_back(reqRow(0, 32'h40, 0, SIZE_W, 4'h0, 1, 0, 0, 1, 4'b1000, 8'h10));
        vecs.push_back(outRow(1, 32'h0, 0, 0, 0));
        vecs.push_back(outRow(0, 0, 1, 4'h0, 8'h10));
        vecs.push_back(outRow(1, 32'hAAADBEEF, 0, 0, 0));
        vecs.push_back(reqRow(0, 32'h44, 32'h0BAD_F00D, SIZE_W, 4'hF, 1, 0, 0, 0, 0, 0));
        vecs.push_back(outRow(0, 0, 1, 4'h0, 8'h11));
        vecs.push_back(outRow(1, 32'h12345678, 0, 0, 0));
        vecs.push_back(reqRow(0, 32'h44, 32'h0BAD_F00D, SIZE_W, 4'hF, 1, 0, 0, 0, 0, 0));
        vecs.push_back(outRow(0, 0, 1, 4'h0, 8'h11));
        vecs.push_back(outRow(1, 32'h12345678, 0, 0, 0));
        vecs.push_back(reqRow(0, 32'h80, 0, SIZE_W, 4'h0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(reqRow(0, 32'h84, 0, SIZE_W, 4'h0, 1, 0, 0, 1, 4'h0, 8'h20));
        vecs.push_back(reqRow(0, 32'h88, 0, SIZE_W, 4'h0, 0, 1, 32'hA0A0_0000, 0, 0, 0));
        vecs.push_back(reqRow(0, 32'h88, 0, SIZE_W, 4'h0, 1, 0, 0, 1, 4'h0, 8'h21));
        vecs.push_back(reqRow(0, 32'h8C, 0, SIZE_W, 4'h0, 0, 1, 32'hA0A0_0001, 0, 0, 0));
        vecs.push_back(reqRow(0, 32'h8C, 0, SIZE_W, 4'h0, 1, 0, 0, 1, 4'h0, 8'h22));
        vecs.push_back(outRow(1, 32'hA0A0_0002, 0, 0, 0));
        vecs.push_back(outRow(0, 0, 1, 4'h0, 8'h23));
        vecs.push_back(outRow(1, 32'hA0A0_0003, 0, 0, 0));
        vecs.push_back(outRow(0, 0, 0, 0, 0));
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, SIZE_W, 4'h0);
        foreach (vecs[i]) begin
            @(posedge clk); #1;
            applyStimulus(0, vecs[i].rst, vecs[i].req, vecs[i].wt, vecs[i].addr, vecs[i].wd,
                          vecs[i].size, vecs[i].we);
            @(negedge clk);
            checkOutput($sformatf("vec%0d.aok", i), 32'(aok_v[0]), 32'(vecs[i].e_aok));
            checkOutput($sformatf("vec%0d.dok", i), 32'(dok_v[0]), 32'(vecs[i].e_dok));
            checkOutput($sformatf("vec%0d.rdata", i), rdata_v[0], vecs[i].e_rdata);
            checkOutput($sformatf("vec%0d.ram_en", i), 32'(en_v[0]), 32'(vecs[i].e_en));
            checkOutput($sformatf("vec%0d.ram_we", i), 32'(rwe_v[0]), 32'(vecs[i].e_we));
            if (vecs[i].e_en)
                checkOutput($sformatf("vec%0d.ram_addr", i), 32'(raddr_v[0]), 32'(vecs[i].e_raddr));
        end
        checkOutput("mem.word11", mem[0][17], 32'h12345678);

        // Three wait states: accept-to-data_ok latency and back-to-back spacing.
        @(posedge clk); #1;
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, SIZE_W, 4'h0);
        @(negedge clk); checkOutput("lat.accept", 32'(aok_v[1]), 1);
        @(posedge clk); #1; req_v[1] = 1'b0;
        waitDataOk(1, 20, n);
        checkOutput("lat.cycles", 32'(n), 5);
        checkOutput("lat.rdata", rdata_v[1], 32'h5555_0001);
        @(posedge clk); #1;
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h104, 32'h0, SIZE_W, 4'h0);
        @(negedge clk); checkOutput("b2b.accept0", 32'(aok_v[1]), 1);
        @(posedge clk); #1; addr_v[1] = 32'h108;
        @(negedge clk); checkOutput("b2b.accept1", 32'(aok_v[1]), 1);
        @(posedge clk); #1; req_v[1] = 1'b0;
        waitDataOk(1, 20, n);
        checkOutput("b2b.first", 32'(n), 4);
        checkOutput("b2b.rdata0", rdata_v[1], 32'h5555_0002);
        waitDataOk(1, 20, n);
        checkOutput("b2b.spacing", 32'(n), 5);
        checkOutput("b2b.rdata1", rdata_v[1], 32'h5555_0003);

        // Reset pulse while two requests are queued and the FSM is waiting.
        @(posedge clk); #1;
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h10C, 32'h0, SIZE_W, 4'h0);
        @(negedge clk); checkOutput("rst.accept0", 32'(aok_v[1]), 1);
        @(posedge clk); #1; addr_v[1] = 32'h110;
        @(negedge clk); checkOutput("rst.accept1", 32'(aok_v[1]), 1);
        @(posedge clk); #1; rst_v[1] = 1'b0; req_v[1] = 1'b1;
        @(negedge clk);
        checkOutput("rst.aok_low", 32'(aok_v[1]), 0);
        checkOutput("rst.en_low", 32'(en_v[1]), 0);
        @(posedge clk); #1; rst_v[1] = 1'b1; addr_v[1] = 32'h114;
        @(negedge clk); checkOutput("rst.first_aok", 32'(aok_v[1]), 1);
        @(posedge clk); #1; req_v[1] = 1'b0;
        nd = 0; ne = 0; first = -1; rd = 32'h0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (dok_v[1]) begin
                nd++;
                if (first < 0) begin first = i; rd = rdata_v[1]; end
            end
            if (en_v[1]) ne++;
        end
        checkOutput("rst.dok_count", 32'(nd), 1);
        checkOutput("rst.dok_cycle", 32'(first), 5);
        checkOutput("rst.en_count", 32'(ne), 1);
        checkOutput("rst.rdata", rd, 32'h6969_0069);

        // Randomized traffic on both instances against the reference model.
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) applyStimulus(k, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, SIZE_W, 4'h0);
        model_on = 1'b1;
        repeat (800) begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) randomDrive(k);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) applyStimulus(k, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, SIZE_W, 4'h0);
        repeat (30) @(posedge clk);
        @(negedge clk);
        model_on = 1'b0;
        checkOutput("drain.u0", 32'(pc[0]), 0);
        checkOutput("drain.u1", 32'(pc[1]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
